// File: rtl/calc_sequencer.sv
// Keypad sequencer for the two-digit calculator: collects A/op/B, runs add/sub/mult/div on '='.
// Define CALC_DIV_EN to accept the divide key and build the restoring divider.
module calc_sequencer #(
  parameter int unsigned RES_W   = 14,
  parameter int unsigned ITER    = 7,
  parameter logic [7:0]  KEY_EQ  = 8'h0E,
  parameter logic [7:0]  KEY_CLR = 8'h0C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [7:0]       key_code,
  output logic [7:0]       A1,
  output logic [7:0]       A0,
  output logic [7:0]       OP,
  output logic [7:0]       B1,
  output logic [7:0]       B0,
  output logic [RES_W-1:0] result,
  output logic [ITER-1:0]  rem,
  output logic             neg,
  output logic             err,
  output logic             busy,
  output logic             done
);

  // Operator key codes shared with the keypad scanner.
  localparam logic [7:0] KeyAdd = 8'h0A;
  localparam logic [7:0] KeySub = 8'h0B;
  localparam logic [7:0] KeyMul = 8'h0F;
`ifdef CALC_DIV_EN
  localparam logic [7:0] KeyDiv = 8'h0D;
`endif
  localparam int unsigned CntW = $clog2(ITER);

  typedef enum logic [2:0] {
    StGetA1, StGetA0, StGetOp, StGetB1, StGetB0, StWaitEq, StExec, StDone
  } state_e;

  state_e state_q, state_d;
  logic [7:0]       a1_q, a1_d, a0_q, a0_d, op_q, op_d, b1_q, b1_d, b0_q, b0_d;
  logic [RES_W-1:0] result_q, result_d, acc_q, acc_d, mcand_q, mcand_d, acc_sum;
  logic [ITER-1:0]  opa_q, opa_d, opb_q, opb_d, a_val, b_val;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_q, neg_d, err_q, err_d;
  logic             is_digit, is_op, last_iter;
`ifdef CALC_DIV_EN
  logic [ITER-1:0]  prem_q, prem_d, rem_q, rem_d, div_rem;
  logic [ITER:0]    div_trial, div_diff;
  logic             div_bit;
`endif

  always_comb begin
    state_d  = state_q;
    a1_d     = a1_q;
    a0_d     = a0_q;
    op_d     = op_q;
    b1_d     = b1_q;
    b0_d     = b0_q;
    result_d = result_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    err_d    = err_q;
`ifdef CALC_DIV_EN
    prem_d   = prem_q;
    rem_d    = rem_q;
    // One restoring step: shift in the next dividend bit, subtract if it fits.
    div_trial = {prem_q, opa_q[ITER-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    div_bit   = (div_trial >= {1'b0, opb_q});
    div_rem   = div_bit ? ITER'(div_diff) : ITER'(div_trial);
`endif
    a_val     = ITER'(a1_q * 8'd10 + a0_q);
    b_val     = ITER'(b1_q * 8'd10 + b0_q);
    acc_sum   = acc_q + (opb_q[0] ? mcand_q : '0);
    last_iter = (cnt_q == CntW'(ITER - 1));
    is_digit  = key_valid && (key_code <= 8'd9);
    is_op     = key_valid && ((key_code == KeyAdd) || (key_code == KeySub) ||
`ifdef CALC_DIV_EN
                              (key_code == KeyDiv) ||
`endif
                              (key_code == KeyMul));

    if (key_valid && key_code == KEY_CLR) begin
      state_d  = StGetA1;
      a1_d     = '0;
      a0_d     = '0;
      op_d     = '0;
      b1_d     = '0;
      b0_d     = '0;
      result_d = '0;
      acc_d    = '0;
      mcand_d  = '0;
      opa_d    = '0;
      opb_d    = '0;
      cnt_d    = '0;
      neg_d    = 1'b0;
      err_d    = 1'b0;
`ifdef CALC_DIV_EN
      prem_d   = '0;
      rem_d    = '0;
`endif
    end else begin
      unique case (state_q)
        StGetA1: if (is_digit) begin a1_d = key_code; state_d = StGetA0; end
        StGetA0: if (is_digit) begin a0_d = key_code; state_d = StGetOp; end
        StGetOp: if (is_op)    begin op_d = key_code; state_d = StGetB1; end
        StGetB1: if (is_digit) begin b1_d = key_code; state_d = StGetB0; end
        StGetB0: if (is_digit) begin b0_d = key_code; state_d = StWaitEq; end
        StWaitEq: begin
          if (key_valid && key_code == KEY_EQ) begin
            opa_d   = a_val;
            opb_d   = b_val;
            mcand_d = RES_W'(a_val);
            acc_d   = '0;
            cnt_d   = '0;
`ifdef CALC_DIV_EN
            prem_d  = '0;
`endif
            state_d = StExec;
          end
        end
        StExec: begin
          cnt_d = cnt_q + 1'b1;
          case (op_q)
            KeyMul: begin
              // Shift-add, multiplier LSB first.
              acc_d   = acc_sum;
              mcand_d = mcand_q << 1;
              opb_d   = opb_q >> 1;
              if (last_iter) begin
                result_d = acc_sum;
                state_d  = StDone;
              end
            end
`ifdef CALC_DIV_EN
            KeyDiv: begin
              if (opb_q == '0) begin
                err_d    = 1'b1;
                result_d = '0;
                rem_d    = '0;
                state_d  = StDone;
              end else begin
                // Dividend register fills with quotient bits from the bottom.
                prem_d = div_rem;
                opa_d  = {opa_q[ITER-2:0], div_bit};
                if (last_iter) begin
                  result_d = RES_W'({opa_q[ITER-2:0], div_bit});
                  rem_d    = div_rem;
                  state_d  = StDone;
                end
              end
            end
`endif
            KeySub: begin
              if (opa_q >= opb_q) begin
                result_d = RES_W'(opa_q - opb_q);
                neg_d    = 1'b0;
              end else begin
                result_d = RES_W'(opb_q - opa_q);
                neg_d    = 1'b1;
              end
              state_d = StDone;
            end
            default: begin
              result_d = RES_W'(opa_q) + RES_W'(opb_q);
              state_d  = StDone;
            end
          endcase
        end
        StDone: begin
          if (is_digit) begin
            result_d = '0;
            neg_d    = 1'b0;
            err_d    = 1'b0;
            op_d     = '0;
            b1_d     = '0;
            b0_d     = '0;
            a1_d     = key_code;
`ifdef CALC_DIV_EN
            rem_d    = '0;
`endif
            state_d  = StGetA0;
          end
        end
        default: state_d = StGetA1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StGetA1;
      a1_q     <= '0;
      a0_q     <= '0;
      op_q     <= '0;
      b1_q     <= '0;
      b0_q     <= '0;
      result_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef CALC_DIV_EN
      prem_q   <= '0;
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a1_q     <= a1_d;
      a0_q     <= a0_d;
      op_q     <= op_d;
      b1_q     <= b1_d;
      b0_q     <= b0_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
`ifdef CALC_DIV_EN
      prem_q   <= prem_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign A1     = a1_q;
  assign A0     = a0_q;
  assign OP     = op_q;
  assign B1     = b1_q;
  assign B0     = b0_q;
  assign result = result_q;
  assign neg    = neg_q;
  assign err    = err_q;
  assign busy   = (state_q == StExec);
  assign done   = (state_q == StDone);
`ifdef CALC_DIV_EN
  assign rem    = rem_q;
`else
  assign rem    = '0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer; keys are driven on the falling edge, outputs checked there.
module tb_calc_sequencer;

  localparam logic [7:0] K_ADD = 8'h0A;
  localparam logic [7:0] K_SUB = 8'h0B;
  localparam logic [7:0] K_CLR = 8'h0C;
  localparam logic [7:0] K_DIV = 8'h0D;
  localparam logic [7:0] K_EQ  = 8'h0E;
  localparam logic [7:0] K_MUL = 8'h0F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic [7:0]  A1, A0, OP, B1, B0;
  logic [13:0] result;
  logic [6:0]  rem;
  logic        neg, err, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  logic watch = 1'b0;
  logic saw_done = 1'b0;

  calc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .A1        (A1),
    .A0        (A0),
    .OP        (OP),
    .B1        (B1),
    .B0        (B0),
    .result    (result),
    .rem       (rem),
    .neg       (neg),
    .err       (err),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (watch && done) saw_done <= 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic enter(input logic [7:0] a1, input logic [7:0] a0, input logic [7:0] op,
                       input logic [7:0] b1, input logic [7:0] b0);
    press(a1); press(a0); press(op); press(b1); press(b0); press(K_EQ);
  endtask

  // Counts busy cycles observed after '=' until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_digits"}, {24'h0, A1, A0, OP, B1, B0}, 64'h0);
    chk({tag, "_res"}, {39'h0, result, rem, neg, err, busy, done}, 64'h0);
  endtask

  initial begin
    // Reset state
    #2 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 12 + 34
    press(8'd1); press(8'd2); press(K_ADD); press(8'd3); press(8'd4);
    chk("entry_echo", {24'h0, A1, A0, OP, B1, B0}, {24'h0, 8'd1, 8'd2, K_ADD, 8'd3, 8'd4});
    press(K_EQ);
    chk("add_busy", {62'h0, busy, done}, 64'b10);
    @(negedge clk);
    chk("add_done", {62'h0, busy, done}, 64'b01);
    chk("add_res", {48'h0, result, neg, err}, {48'h0, 14'd46, 1'b0, 1'b0});

    // 05 - 20 entered straight from DONE
    press(8'd0);
    chk("new_entry_clr", {48'h0, result, done, A1}, {48'h0, 14'd0, 1'b0, 8'd0});
    press(8'd5); press(K_SUB); press(8'd2); press(8'd0); press(K_EQ);
    @(negedge clk);
    chk("sub_neg", {48'h0, result, neg, done}, {48'h0, 14'd15, 1'b1, 1'b1});
    press(8'd7);
    chk("sub_next", {40'h0, result, done, neg, A1}, {40'h0, 14'd0, 1'b0, 1'b0, 8'd7});
    chk("sub_next_digits", {32'h0, A0, OP, B1, B0}, {32'h0, 8'd5, 8'd0, 8'd0, 8'd0});

    // 99 + 99 and 42 - 42 boundaries
    press(K_CLR);
    chk_zero("clr1");
    enter(8'd9, 8'd9, K_ADD, 8'd9, 8'd9);
    @(negedge clk);
    chk("add_max", {48'h0, result, neg, done}, {48'h0, 14'd198, 1'b0, 1'b1});
    enter(8'd4, 8'd2, K_SUB, 8'd4, 8'd2);
    @(negedge clk);
    chk("sub_zero", {48'h0, result, neg, done}, {48'h0, 14'd0, 1'b0, 1'b1});

    // 99 * 99
    press(K_CLR);
    enter(8'd9, 8'd9, K_MUL, 8'd9, 8'd9);
    wait_idle(cyc);
    chk("mul_busy_cycles", 64'(cyc), 64'd7);
    chk("mul_res", {48'h0, result, neg, done}, {48'h0, 14'd9801, 1'b0, 1'b1});

    // Misplaced keys, then clear during EXEC of 12*34
    press(K_CLR);
    press(K_ADD); press(8'd1); press(K_EQ); press(8'd2);
    press(8'd4);
    chk("misplaced_op", {32'h0, A1, A0, OP, B1}, {32'h0, 8'd1, 8'd2, 8'd0, 8'd0});
    press(K_MUL); press(K_ADD); press(8'd3); press(K_EQ); press(8'd4); press(8'd4);
    chk("misplaced_b", {40'h0, OP, B1, B0}, {40'h0, K_MUL, 8'd3, 8'd4});
    chk("wait_eq_idle", {62'h0, busy, done}, 64'b00);
    watch = 1'b1;
    press(K_EQ);
    press(8'd5);
    chk("exec_ignores", {55'h0, busy, B0}, {55'h0, 1'b1, 8'd4});
    press(K_CLR);
    chk_zero("exec_clr");
    repeat (10) @(negedge clk);
    chk("no_done_after_abort", {63'h0, saw_done}, 64'h0);
    watch = 1'b0;
    press(8'd5);
    chk("clr_to_a1", {48'h0, A1, A0}, {48'h0, 8'd5, 8'd0});

    // Async reset during EXEC of 99*99
    press(K_CLR);
    enter(8'd9, 8'd9, K_MUL, 8'd9, 8'd9);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {63'h0, busy}, 64'h1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    press(8'd3);
    chk("post_reset_a1", {48'h0, A1, A0}, {48'h0, 8'd3, 8'd0});

    press(K_CLR);
`ifdef CALC_DIV_EN
    enter(8'd8, 8'd7, K_DIV, 8'd0, 8'd4);
    wait_idle(cyc);
    chk("div_busy_cycles", 64'(cyc), 64'd7);
    chk("div_res", {40'h0, result, rem, err, done}, {40'h0, 14'd21, 7'd3, 1'b0, 1'b1});
    enter(8'd5, 8'd0, K_DIV, 8'd0, 8'd0);
    @(negedge clk);
    chk("div_zero", {40'h0, result, rem, err, done}, {40'h0, 14'd0, 7'd0, 1'b1, 1'b1});
`else
    press(8'd8); press(8'd7); press(K_DIV);
    chk("div_ignored", {56'h0, OP}, 64'h0);
    press(K_ADD);
    chk("still_get_op", {56'h0, OP}, {56'h0, K_ADD});
    press(8'd0); press(8'd4); press(K_EQ);
    @(negedge clk);
    chk("div_off_add", {40'h0, result, rem, err, done}, {40'h0, 14'd91, 7'd0, 1'b0, 1'b1});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
